sram_controller: RTL
====================

# sram_controller

Multi-cycle controller between the pipeline's memory stage and the board's external 256K×16 asynchronous SRAM. It turns one 32-bit load or store into two 16-bit SRAM accesses, low half first, each lasting `WAIT_CYCLES` clocks. While an access is in flight it holds `ready` low; the top level uses `~ready` as the pipeline-wide freeze.

## Interface
- `WAIT_CYCLES`, 3, clocks per 16-bit half access; legal values ≥2.
- `DATA_BASE`, 1024, byte address that maps to SRAM word 0.
- `clk` input 1 system clock; all state updates on the rising edge.
- `rst` input 1 reset, asynchronous, active-low.
- `wr_en` input 1 store request from the memory stage, held until `ready`.
- `rd_en` input 1 load request from the memory stage, held until `ready`.
- `address` input 32 byte address; word aligned.
- `write_data` input 32 store data.
- `read_data` output 32 load result; registered.
- `ready` output 1 high when no request is pending or the access completes this cycle.
- `SRAM_DQ` inout 16 SRAM data bus.
- `SRAM_ADDR` output 18 SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N` output 1 each, SRAM write and output enables, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each, tied to 0.

## Operation
- **FSM states:** IDLE, LO, HI, DONE. Wait counter `cnt` runs 0..WAIT_CYCLES-1.
- **IDLE:**
  - If `wr_en|rd_en`, latch the request and go to LO with `cnt`=0.
  - Latched fields: `is_wr`=`wr_en`, `word`=((`address`−DATA_BASE)>>2)[16:0], and `write_data`.
  - Both enables high counts as a write (write priority).
- **LO/HI:** `cnt` increments each cycle. On `cnt`==WAIT_CYCLES-1, clear `cnt` and advance LO→HI→DONE.
- **DONE:** lasts one cycle, then returns to IDLE unconditionally. The request seen in the next IDLE cycle belongs to the next instruction.
- **`SRAM_ADDR`:**
  - `{word,1'b0}` in LO.
  - `{word,1'b1}` in HI.
  - 0 otherwise.
- **Write phases:**
  - `SRAM_DQ` drives `data[15:0]` in LO and `data[31:16]` in HI.
  - `SRAM_WE_N`=0 for `cnt`<WAIT_CYCLES-1 and 1 on the final cycle of the phase, which gives address/data hold.
  - `SRAM_OE_N`=1.
- **Read phases:**
  - `SRAM_DQ` is high-Z and `SRAM_OE_N`=0.
  - On the final cycle of LO, capture `SRAM_DQ` into `read_data[15:0]`; on the final cycle of HI, into `read_data[31:16]`.
- **Bus default:** outside the write phases `SRAM_DQ` is always high-Z. The controller and the SRAM never drive the bus at the same time.
- **`ready`:** combinational, `ready = (state==IDLE & ~(wr_en|rd_en)) | state==DONE`.
- **Writes:** `read_data` is unchanged by writes.
- **Address arithmetic:** subtraction wraps modulo 2^32 and only bits [18:2] are used, so out-of-range addresses alias; no error is flagged.

## Timing
- Request first seen in IDLE at cycle 0:
  - LO covers cycles 1..W.
  - HI covers cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready`=1 and `read_data` valid.
  - Total freeze is 2W+1 cycles; with the default W=3, `ready` rises at cycle 7.
- Back-to-back requests: the second one is seen in IDLE at cycle 2W+2, so there is no idle gap beyond that IDLE cycle.
- Inputs are ignored outside IDLE; changes mid-access have no effect.
- **Reset values** (apply immediately on `rst` low, including mid-access; no partial write is completed):
  - State IDLE, `cnt`=0.
  - `read_data`=0, latched request=0.
  - `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ` high-Z.
  - `ready` = ~(wr_en|rd_en).

## Structure
- **Shared package `arm_mem_pkg`:**
  - State enum `sram_state_t` {IDLE, LO, HI, DONE}.
  - `DATA_MEM_BASE`=1024.
  - `SRAM_ADDR_W`=18, `SRAM_DATA_W`=16.
- **RTL:** a single module; the wait counter is inline and no sub-module is warranted.
- **Bench:** uses a separate behavioural `sram_model` (256K×16 array, combinational read, write on the rising edge of `SRAM_WE_N` or while it is low).

## Test plan
- **Idle:** no request for 10 cycles → `ready`=1 throughout, `SRAM_WE_N`=`SRAM_OE_N`=1, `SRAM_DQ` high-Z.
- **Store, W=3:** store 0xDEADBEEF to address 1024 → `sram_model[0]`=0xBEEF and `[1]`=0xDEAD; `ready` low for cycles 0–6 and high at cycle 7.
- **Load after store:** load from 1024 after the store above → `read_data`=0xDEADBEEF in the DONE cycle; `SRAM_ADDR` 0 in LO, 1 in HI.
- **Back-to-back:** store 0x12345678 to 1028, then immediately load 1028 → `SRAM_ADDR` 2/3; load returns 0x12345678; the second request starts in the IDLE cycle directly after DONE.
- **Simultaneous enables:** `wr_en`=`rd_en`=1 → treated as a write and memory is updated; `read_data` keeps its previous value.
- **Reset mid-access:** `rst` low during HI of a store → immediate IDLE, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `read_data`=0. After release, a fresh load of 1024 completes normally in 2W+1 cycles.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory stage and its external 256Kx16 asynchronous SRAM.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int DATA_MEM_BASE = 1024;
  localparam int SRAM_ADDR_W   = 18;
  localparam int SRAM_DATA_W   = 16;

  // Out-of-range addresses alias silently: the subtraction wraps and only bits [18:2] survive.
  function automatic logic [SRAM_ADDR_W-2:0] sram_word_of(input logic [31:0] addr,
                                                         input logic [31:0] base);
    return (SRAM_ADDR_W-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two WAIT_CYCLES-long 16-bit SRAM accesses, low half first.
// ready stays low (pipeline freeze) from the cycle a request is seen until the DONE cycle.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int DATA_BASE   = DATA_MEM_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t              r_state;
  sram_state_t              w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     r_is_wr;
  logic [SRAM_ADDR_W-2:0]   r_word;
  logic [31:0]              r_wdata;
  logic [31:0]              r_read_data;

  logic                     w_req;
  logic                     w_active;
  logic                     w_last;
  logic                     w_drive;
  logic [SRAM_DATA_W-1:0]   w_dq_out;

  assign w_req    = wr_en | rd_en;
  assign w_active = (r_state == LO) || (r_state == HI);
  assign w_last   = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
        end
      end
      LO: begin
        if (w_last) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HI: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Both enables together are treated as a store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_is_wr <= wr_en;
      r_word  <= sram_word_of(address, 32'(DATA_BASE));
      r_wdata <= write_data;
    end
  end

  // The SRAM output has been valid for the whole phase by its final cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= '0;
    end else if (!r_is_wr && w_last) begin
      if (r_state == LO) begin
        r_read_data[15:0] <= SRAM_DQ;
      end else if (r_state == HI) begin
        r_read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign w_drive  = w_active && r_is_wr;
  assign w_dq_out = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];

  assign SRAM_DQ   = w_drive ? w_dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = w_active ? {r_word, (r_state == HI)} : '0;
  // WE_N rises one cycle before the phase ends so address and data are held past the write edge.
  assign SRAM_WE_N = ~(w_drive && !w_last);
  assign SRAM_OE_N = ~(w_active && !r_is_wr);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign read_data = r_read_data;
  assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);

endmodule
